// File: rtl/jk_latch_ctrl_if.sv
// Bundle of requester, latch-bank and status signals for jk_latch_ctrl.
// The master side is the requesters plus latch feedback; the slave side is the controller.
interface jk_latch_ctrl_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     cmd;
  logic [WIDTH*NREQ-1:0] mask;
  logic [WIDTH-1:0]      latch_q;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      latch_j;
  logic [WIDTH-1:0]      latch_k;
  logic                  latch_en;
  logic                  err;

  modport master (
    output req, cmd, mask, latch_q,
    input  gnt, busy, done, latch_j, latch_k, latch_en, err
  );

  modport slave (
    input  req, cmd, mask, latch_q,
    output gnt, busy, done, latch_j, latch_k, latch_en, err
  );
endinterface

// File: rtl/jk_latch_ctrl.sv
// Round-robin sequencer driving a shared JK latch bank: setup -> enable pulse -> release.
// Optional readback check of the latch bank is enabled with `define JK_LATCH_CTRL_VERIFY_EN.
module jk_latch_ctrl #(
  parameter int NREQ      = 2,
  parameter int WIDTH     = 4,
  parameter int EN_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  jk_latch_ctrl_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_PULSE   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] C_HOLD   = 2'b00;
  localparam logic [1:0] C_RESET  = 2'b01;
  localparam logic [1:0] C_SET    = 2'b10;
  localparam logic [1:0] C_TOGGLE = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             en_q, en_d;

  logic [1:0]       cmd_arr  [NREQ];
  logic [WIDTH-1:0] mask_arr [NREQ];
  logic             found;
  logic [PTR_W-1:0] win;
  int               idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cmd_arr[i]  = bus.cmd[2*i +: 2];
      mask_arr[i] = bus.mask[WIDTH*i +: WIDTH];
    end
  end

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    j_d     = j_q;
    k_d     = k_q;
    en_d    = en_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_SETUP;
          cmd_d      = cmd_arr[win];
          mask_d     = mask_arr[win];
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          ptr_d      = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      S_SETUP: begin
        // TOGGLE is resolved against the live latch state so j and k are never both high.
        case (cmd_q)
          C_RESET:  begin j_d = '0;                       k_d = mask_q;                 end
          C_SET:    begin j_d = mask_q;                   k_d = '0;                     end
          C_TOGGLE: begin j_d = mask_q & ~bus.latch_q;    k_d = mask_q & bus.latch_q;   end
          default:  begin j_d = '0;                       k_d = '0;                     end
        endcase
        if (cmd_q == C_HOLD) begin
          state_d = S_RELEASE;
          en_d    = 1'b0;
        end else begin
          state_d = S_PULSE;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(EN_CYCLES - 1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_RELEASE;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        j_d     = '0;
        k_d     = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        j_d     = '0;
        k_d     = '0;
        en_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cmd_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      j_q     <= j_d;
      k_q     <= k_d;
      en_q    <= en_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.latch_j  = j_q;
  assign bus.latch_k  = k_q;
  assign bus.latch_en = en_q;

`ifdef JK_LATCH_CTRL_VERIFY_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q, err_d;

  // Expected readback is fixed at SETUP from the same latch sample used for TOGGLE.
  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (state_q == S_SETUP) begin
      case (cmd_q)
        C_SET:    exp_d = mask_q;
        C_RESET:  exp_d = '0;
        C_TOGGLE: exp_d = ~bus.latch_q & mask_q;
        default:  exp_d = bus.latch_q & mask_q;
      endcase
    end
    if ((state_q == S_DONE) && ((bus.latch_q & mask_q) != exp_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_jk_latch_ctrl.sv
// Directed self-checking bench for jk_latch_ctrl (NREQ=2, WIDTH=4, EN_CYCLES=2).
module tb_jk_latch_ctrl;
  localparam int NREQ      = 2;
  localparam int WIDTH     = 4;
  localparam int EN_CYCLES = 2;
`ifdef JK_LATCH_CTRL_VERIFY_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  jk_latch_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  jk_latch_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .EN_CYCLES(EN_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // j and k must never both be high on any bit.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if ((bus.latch_j & bus.latch_k) !== 4'b0000) begin
        n_fail++;
        $display("FAIL jk_overlap: j=%b k=%b required j&k=0000", bus.latch_j, bus.latch_k);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.cmd = '0; bus.mask = '0; bus.latch_q = '0;
    step();
    n_tests++;
    if ({bus.gnt, bus.busy, bus.done, bus.latch_j, bus.latch_k, bus.latch_en, bus.err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b busy=%b done=%b j=%b k=%b en=%b err=%b required all 0",
               bus.gnt, bus.busy, bus.done, bus.latch_j, bus.latch_k, bus.latch_en, bus.err);
    end
    rst = 1'b0;
    // SET on req0, then reset in the middle of the enable pulse.
    bus.req = 2'b01; bus.cmd = 4'b0010; bus.mask = 8'h05;
    step(); step();
    n_tests++;
    if (bus.latch_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_pulse_en: got %b required 1", bus.latch_en);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.latch_en, bus.gnt, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async_drop: en=%b gnt=%b busy=%b required 0 00 0", bus.latch_en, bus.gnt, bus.busy);
    end
    bus.req = '0;
    step();
    rst = 1'b0;
    step();
    n_tests++;
    if ({bus.gnt, bus.busy, bus.done, bus.latch_j, bus.latch_k, bus.latch_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_after_release: gnt=%b busy=%b done=%b j=%b k=%b en=%b required all 0",
               bus.gnt, bus.busy, bus.done, bus.latch_j, bus.latch_k, bus.latch_en);
    end
  endtask

  task automatic test_single_set();
    bus.latch_q = 4'b0000;
    bus.req = 2'b01; bus.cmd = 4'b0010; bus.mask = 8'h05;
    step();
    n_tests++;
    if ({bus.gnt, bus.busy, bus.latch_en} !== 4'b0110) begin
      n_fail++;
      $display("FAIL set_c1: gnt=%b busy=%b en=%b required 01 1 0", bus.gnt, bus.busy, bus.latch_en);
    end
    for (int c = 2; c <= 3; c++) begin
      step();
      n_tests++;
      if ({bus.latch_j, bus.latch_k, bus.latch_en} !== 9'b0101_0000_1) begin
        n_fail++;
        $display("FAIL set_pulse_c%0d: j=%b k=%b en=%b required 0101 0000 1", c, bus.latch_j, bus.latch_k, bus.latch_en);
      end
    end
    step();
    n_tests++;
    if ({bus.latch_j, bus.latch_en, bus.done} !== 6'b0101_0_0) begin
      n_fail++;
      $display("FAIL set_release: j=%b en=%b done=%b required 0101 0 0", bus.latch_j, bus.latch_en, bus.done);
    end
    step();
    n_tests++;
    if ({bus.done, bus.gnt, bus.latch_j, bus.latch_k} !== 11'b1_01_0000_0000) begin
      n_fail++;
      $display("FAIL set_done_c5: done=%b gnt=%b j=%b k=%b required 1 01 0000 0000", bus.done, bus.gnt, bus.latch_j, bus.latch_k);
    end
    bus.req = '0;
    step();
    n_tests++;
    if ({bus.done, bus.gnt, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL set_idle: done=%b gnt=%b busy=%b required 0 00 0", bus.done, bus.gnt, bus.busy);
    end
  endtask

  task automatic test_toggle();
    bus.latch_q = 4'b0011;
    bus.req = 2'b01; bus.cmd = 4'b0011; bus.mask = 8'h0F;
    step(); step();
    n_tests++;
    if ({bus.latch_j, bus.latch_k, bus.latch_en} !== 9'b1100_0011_1) begin
      n_fail++;
      $display("FAIL toggle_pulse: j=%b k=%b en=%b required 1100 0011 1", bus.latch_j, bus.latch_k, bus.latch_en);
    end
    step(); step(); step();
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_done: got %b required 1", bus.done);
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.latch_q = 4'b0000;
    bus.req = 2'b11; bus.cmd = 4'b1010; bus.mask = 8'h31;
    for (int t = 0; t < 4; t++) begin
      step();
      n_tests++;
      if (bus.gnt !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rr_gnt_%0d: got %b required %b", t, bus.gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
      end
      step();
      n_tests++;
      if (bus.latch_j !== ((t % 2 == 0) ? 4'b0001 : 4'b0011)) begin
        n_fail++;
        $display("FAIL rr_mask_%0d: j=%b required %b", t, bus.latch_j, (t % 2 == 0) ? 4'b0001 : 4'b0011);
      end
      step(); step(); step();
      n_tests++;
      if (bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_done_%0d: got %b required 1", t, bus.done);
      end
      if (t == 3) bus.req = '0;
      step();
      n_tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_gap_%0d: busy=%b done=%b required 0 0", t, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_hold_and_drop();
    bus.req = 2'b10; bus.cmd = 4'b0010; bus.mask = 8'hF0;
    step();
    n_tests++;
    if ({bus.gnt, bus.latch_en} !== 3'b10_0) begin
      n_fail++;
      $display("FAIL hold_c1: gnt=%b en=%b required 10 0", bus.gnt, bus.latch_en);
    end
    step();
    n_tests++;
    if ({bus.latch_en, bus.latch_j, bus.latch_k, bus.done} !== 10'b0) begin
      n_fail++;
      $display("FAIL hold_c2: en=%b j=%b k=%b done=%b required 0 0000 0000 0", bus.latch_en, bus.latch_j, bus.latch_k, bus.done);
    end
    step();
    n_tests++;
    if ({bus.done, bus.latch_en, bus.gnt} !== 4'b1_0_10) begin
      n_fail++;
      $display("FAIL hold_done_c3: done=%b en=%b gnt=%b required 1 0 10", bus.done, bus.latch_en, bus.gnt);
    end
    bus.req = '0;
    step();
    // SET on req0 with req and cmd/mask changed after capture.
    bus.req = 2'b01; bus.cmd = 4'b0010; bus.mask = 8'h03;
    step(); step();
    bus.req = '0; bus.cmd = 4'b0011; bus.mask = 8'h0F;
    step();
    n_tests++;
    if ({bus.latch_j, bus.latch_k, bus.latch_en} !== 9'b0011_0000_1) begin
      n_fail++;
      $display("FAIL drop_pulse: j=%b k=%b en=%b required 0011 0000 1", bus.latch_j, bus.latch_k, bus.latch_en);
    end
    step(); step();
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_done: got %b required 1", bus.done);
    end
    step();
  endtask

  task automatic test_mask_zero();
    bus.req = 2'b01; bus.cmd = 4'b0001; bus.mask = 8'h00;
    step(); step();
    n_tests++;
    if ({bus.latch_j, bus.latch_k, bus.latch_en} !== 9'b0000_0000_1) begin
      n_fail++;
      $display("FAIL mask0_pulse: j=%b k=%b en=%b required 0000 0000 1", bus.latch_j, bus.latch_k, bus.latch_en);
    end
    step(); step(); step();
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL mask0_done: got %b required 1", bus.done);
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_verify();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.latch_q = 4'b0000;
    bus.req = 2'b01; bus.cmd = 4'b0010; bus.mask = 8'h01;
    for (int c = 1; c <= 5; c++) step();
    n_tests++;
    if ({bus.done, bus.err} !== 2'b10) begin
      n_fail++;
      $display("FAIL verify_done: done=%b err=%b required 1 0", bus.done, bus.err);
    end
    bus.req = '0;
    step();
    n_tests++;
    if (bus.err !== EXP_ERR) begin
      n_fail++;
      $display("FAIL verify_err_set: got %b required %b", bus.err, EXP_ERR);
    end
    step(); step();
    n_tests++;
    if (bus.err !== EXP_ERR) begin
      n_fail++;
      $display("FAIL verify_err_sticky: got %b required %b", bus.err, EXP_ERR);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_err_clear: got %b required 0", bus.err);
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_toggle();
    test_round_robin();
    test_hold_and_drop();
    test_mask_zero();
    test_verify();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
